// File: rtl/aes_sbox_pkg.sv
// Shared types and constants for the time-multiplexed AES S-box bank.
// Pass counts are derived from the number of physical lanes.
package aes_sbox_pkg;

    localparam int BYTE_W   = 8;
    localparam int SB_BYTES = 16;
    localparam int SW_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN_SB  = 3'd1,
        RUN_SW  = 3'd2,
        DONE_SB = 3'd3,
        DONE_SW = 3'd4
    } state_e;

    typedef enum logic {
        GRANT_SB = 1'b0,
        GRANT_SW = 1'b1
    } grant_e;

    function automatic bit lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4);
    endfunction

    function automatic int pass_count(input int lanes, input int nbytes);
        return nbytes / lanes;
    endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Purely combinational; the inverse is x^254.
module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] acc;
        p   = 8'h00;
        acc = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ acc;
            acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Square-and-multiply over exponent 0xfe; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] base;
        logic [7:0] e;
        r    = 8'h01;
        base = x;
        e    = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Shares LANES S-box instances between the SubBytes state and the SubWord key path.
// Round-robin on ties, no preemption; each job walks its bytes LANES at a time.
module sbox_share_ctrl
    import aes_sbox_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sb_valid,
    output logic         sb_ready,
    input  logic [127:0] sb_data,
    output logic         sb_out_valid,
    input  logic         sb_out_ready,
    output logic [127:0] sb_out,
    input  logic         sw_valid,
    output logic         sw_ready,
    input  logic [31:0]  sw_word,
    output logic         sw_out_valid,
    input  logic         sw_out_ready,
    output logic [31:0]  sw_out,
    output logic         busy
);

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("sbox_share_ctrl: LANES must be 1, 2 or 4");
    end

    localparam int         SB_P    = pass_count(LANES, SB_BYTES);
    localparam int         SW_P    = pass_count(LANES, SW_BYTES);
    localparam logic [3:0] SB_LAST = 4'(SB_P - 1);
    localparam logic [3:0] SW_LAST = 4'(SW_P - 1);

    state_e       state;
    grant_e       last_grant;
    logic [3:0]   cnt;
    logic [127:0] work;
    logic [127:0] sb_res;
    logic [31:0]  sw_res;

    logic [3:0]        bidx     [LANES];
    logic [BYTE_W-1:0] lane_in  [LANES];
    logic [BYTE_W-1:0] lane_out [LANES];

    // Byte position handled by each lane in the current pass.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign bidx[l]    = 4'(cnt * LANES + l);
        assign lane_in[l] = work[{bidx[l], 3'b000} +: BYTE_W];
        sbox u_sbox (
            .a (lane_in[l]),
            .y (lane_out[l])
        );
    end

    // Readies depend only on registered state and the competing request.
    assign sb_ready = (state == IDLE) && (!sw_valid || last_grant == GRANT_SW);
    assign sw_ready = (state == IDLE) && (!sb_valid || last_grant == GRANT_SB);
    assign busy     = (state != IDLE);
    assign sb_out   = sb_res;
    assign sw_out   = sw_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= GRANT_SB;
            cnt          <= 4'd0;
            sb_res       <= '0;
            sw_res       <= '0;
            sb_out_valid <= 1'b0;
            sw_out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sb_valid && sb_ready) begin
                        work       <= sb_data;
                        sb_res     <= '0;
                        cnt        <= 4'd0;
                        last_grant <= GRANT_SB;
                        state      <= RUN_SB;
                    end else if (sw_valid && sw_ready) begin
                        work       <= {96'd0, sw_word};
                        sw_res     <= '0;
                        cnt        <= 4'd0;
                        last_grant <= GRANT_SW;
                        state      <= RUN_SW;
                    end
                end
                RUN_SB: begin
                    for (int l = 0; l < LANES; l++)
                        sb_res[{bidx[l], 3'b000} +: BYTE_W] <= lane_out[l];
                    cnt <= cnt + 4'd1;
                    if (cnt == SB_LAST) begin
                        state        <= DONE_SB;
                        sb_out_valid <= 1'b1;
                    end
                end
                RUN_SW: begin
                    for (int l = 0; l < LANES; l++)
                        sw_res[{bidx[l][1:0], 3'b000} +: BYTE_W] <= lane_out[l];
                    cnt <= cnt + 4'd1;
                    if (cnt == SW_LAST) begin
                        state        <= DONE_SW;
                        sw_out_valid <= 1'b1;
                    end
                end
                DONE_SB: begin
                    if (sb_out_ready) begin
                        sb_out_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                DONE_SW: begin
                    if (sw_out_ready) begin
                        sw_out_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Bench for sbox_share_ctrl: three instances (LANES 4, 2, 1) checked against an
// S-box model built from field inversion by exhaustive search plus the affine map.
module tb_sbox_share_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   sb_valid, sb_ready, sb_out_valid, sb_out_ready;
    logic [2:0]   sw_valid, sw_ready, sw_out_valid, sw_out_ready, busy;
    logic [127:0] sb_data [3];
    logic [127:0] sb_out  [3];
    logic [31:0]  sw_word [3];
    logic [31:0]  sw_out  [3];

    int total = 0;
    int bad   = 0;
    logic [7:0] sbt [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sbox_share_ctrl #(.LANES(4 >> g)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .sb_valid     (sb_valid[g]),
            .sb_ready     (sb_ready[g]),
            .sb_data      (sb_data[g]),
            .sb_out_valid (sb_out_valid[g]),
            .sb_out_ready (sb_out_ready[g]),
            .sb_out       (sb_out[g]),
            .sw_valid     (sw_valid[g]),
            .sw_ready     (sw_ready[g]),
            .sw_word      (sw_word[g]),
            .sw_out_valid (sw_out_valid[g]),
            .sw_out_ready (sw_out_ready[g]),
            .sw_out       (sw_out[g]),
            .busy         (busy[g])
        );
    end

    function automatic int lanes_of(input int k);
        return 4 >> k;
    endfunction

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] prod;
        logic [14:0] poly;
        prod = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) begin
            poly = 15'h11b << (i - 8);
            if (prod[i]) prod = prod ^ poly;
        end
        return prod[7:0];
    endfunction

    task automatic build_table();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sbt[x] = s;
        end
    endtask

    function automatic logic [127:0] model_sub(input logic [127:0] d, input int nb);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < nb; i++) r[8*i +: 8] = sbt[d[8*i +: 8]];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            if ({sb_out_valid[k], sw_out_valid[k], busy[k]} !== 3'b000) begin
                bad++;
                $display("FAIL reset_ctrl dut%0d: got sbv/swv/busy=%b want 000", k,
                         {sb_out_valid[k], sw_out_valid[k], busy[k]});
            end
            total++;
            if ({sb_ready[k], sw_ready[k]} !== 2'b11) begin
                bad++;
                $display("FAIL reset_ready dut%0d: got %b want 11", k, {sb_ready[k], sw_ready[k]});
            end
            total++;
            if (sb_out[k] !== 128'd0 || sw_out[k] !== 32'd0) begin
                bad++;
                $display("FAIL reset_data dut%0d: got sb=%h sw=%h want 0", k, sb_out[k], sw_out[k]);
            end
            total++;
        end
        rst = 1'b0;
        step();
    endtask

    task automatic run_sb_job(input int k, input logic [127:0] d, input bit early);
        logic [127:0] exp;
        int n;
        exp = model_sub(d, 16);
        n = 0;
        while (!sb_ready[k] && n < 50) begin step(); n++; end
        sb_valid[k] = 1'b1;
        sb_data[k] = d;
        sb_out_ready[k] = early;
        step();
        sb_valid[k] = 1'b0;
        sb_data[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
        #1;
        if (busy[k] !== 1'b1) begin
            bad++;
            $display("FAIL sb_accept dut%0d: busy=%b want 1", k, busy[k]);
        end
        total++;
        n = 0;
        while (!sb_out_valid[k] && n < 100) begin step(); n++; end
        if (n != 16 / lanes_of(k)) begin
            bad++;
            $display("FAIL sb_latency dut%0d: got %0d want %0d", k, n, 16 / lanes_of(k));
        end
        total++;
        if (sb_out[k] !== exp || sw_out_valid[k] !== 1'b0) begin
            bad++;
            $display("FAIL sb_result dut%0d: got %h swv=%b want %h swv=0", k, sb_out[k],
                     sw_out_valid[k], exp);
        end
        total++;
        if (!early) repeat ($urandom_range(0, 3)) step();
        sb_out_ready[k] = 1'b1;
        step();
        sb_out_ready[k] = 1'b0;
        if (sb_out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || sb_out[k] !== exp) begin
            bad++;
            $display("FAIL sb_release dut%0d: got v=%b busy=%b out=%h want v=0 busy=0 out=%h",
                     k, sb_out_valid[k], busy[k], sb_out[k], exp);
        end
        total++;
    endtask

    task automatic run_sw_job(input int k, input logic [31:0] w, input bit early);
        logic [127:0] full;
        logic [31:0] exp;
        int n;
        full = model_sub({96'd0, w}, 4);
        exp = full[31:0];
        n = 0;
        while (!sw_ready[k] && n < 50) begin step(); n++; end
        sw_valid[k] = 1'b1;
        sw_word[k] = w;
        sw_out_ready[k] = early;
        step();
        sw_valid[k] = 1'b0;
        sw_word[k] = $urandom();
        #1;
        if (busy[k] !== 1'b1) begin
            bad++;
            $display("FAIL sw_accept dut%0d: busy=%b want 1", k, busy[k]);
        end
        total++;
        n = 0;
        while (!sw_out_valid[k] && n < 100) begin step(); n++; end
        if (n != 4 / lanes_of(k)) begin
            bad++;
            $display("FAIL sw_latency dut%0d: got %0d want %0d", k, n, 4 / lanes_of(k));
        end
        total++;
        if (sw_out[k] !== exp || sb_out_valid[k] !== 1'b0) begin
            bad++;
            $display("FAIL sw_result dut%0d: got %h sbv=%b want %h sbv=0", k, sw_out[k],
                     sb_out_valid[k], exp);
        end
        total++;
        if (!early) repeat ($urandom_range(0, 3)) step();
        sw_out_ready[k] = 1'b1;
        step();
        sw_out_ready[k] = 1'b0;
        if (sw_out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || sw_out[k] !== exp) begin
            bad++;
            $display("FAIL sw_release dut%0d: got v=%b busy=%b out=%h want v=0 busy=0 out=%h",
                     k, sw_out_valid[k], busy[k], sw_out[k], exp);
        end
        total++;
    endtask

    task automatic test_vectors(input int k);
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i);
        run_sb_job(k, d, 1'b0);
        if (sb_out[k] !== 128'h76abd7fe2b670130c56f6bf27b777c63) begin
            bad++;
            $display("FAIL sb_known dut%0d: got %h want 76abd7fe2b670130c56f6bf27b777c63", k, sb_out[k]);
        end
        total++;
        run_sw_job(k, 32'hff7d0052, 1'b0);
        if (sw_out[k] !== 32'h16ff6300) begin
            bad++;
            $display("FAIL sw_known1 dut%0d: got %h want 16ff6300", k, sw_out[k]);
        end
        total++;
        run_sw_job(k, 32'h00000000, 1'b1);
        if (sw_out[k] !== 32'h63636363) begin
            bad++;
            $display("FAIL sw_known0 dut%0d: got %h want 63636363", k, sw_out[k]);
        end
        total++;
    endtask

    task automatic test_random(input int k);
        for (int j = 0; j < 8; j++) begin
            if ($urandom_range(0, 1) == 0)
                run_sb_job(k, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)));
            else
                run_sw_job(k, $urandom(), 1'($urandom_range(0, 1)));
        end
    endtask

    // Both requesters wait on the other's job, then alternate on ties.
    task automatic test_tie();
        logic [127:0] d;
        logic [127:0] wexp;
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        sb_valid[0] = 1'b1;
        sb_data[0] = d;
        sw_valid[0] = 1'b1;
        sw_word[0] = 32'h0a1b2c3d;
        wexp = model_sub({96'd0, 32'h0a1b2c3d}, 4);
        #1;
        if ({sb_ready[0], sw_ready[0]} !== 2'b01) begin
            bad++;
            $display("FAIL tie_first: got sb/sw ready=%b want 01", {sb_ready[0], sw_ready[0]});
        end
        total++;
        step();
        sw_valid[0] = 1'b0;
        n = 0;
        while (!sw_out_valid[0] && n < 20) begin
            if (sb_ready[0] !== 1'b0) begin
                bad++;
                $display("FAIL tie_sb_wait: sb_ready=%b want 0", sb_ready[0]);
            end
            total++;
            step();
            n++;
        end
        if (sw_out[0] !== wexp[31:0] || sb_ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL tie_sw_done: got %h sb_ready=%b want %h sb_ready=0", sw_out[0],
                     sb_ready[0], wexp[31:0]);
        end
        total++;
        sw_out_ready[0] = 1'b1;
        step();
        sw_out_ready[0] = 1'b0;
        if (sb_ready[0] !== 1'b1 || sw_out_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL tie_sb_turn: got sb_ready=%b swv=%b want 1 0", sb_ready[0], sw_out_valid[0]);
        end
        total++;
        step();
        sb_valid[0] = 1'b0;
        n = 0;
        while (!sb_out_valid[0] && n < 20) begin step(); n++; end
        if (sb_out[0] !== model_sub(d, 16)) begin
            bad++;
            $display("FAIL tie_sb_result: got %h want %h", sb_out[0], model_sub(d, 16));
        end
        total++;
        sb_out_ready[0] = 1'b1;
        step();
        sb_out_ready[0] = 1'b0;
        sb_valid[0] = 1'b1;
        sw_valid[0] = 1'b1;
        #1;
        if ({sb_ready[0], sw_ready[0]} !== 2'b01) begin
            bad++;
            $display("FAIL tie_second: got sb/sw ready=%b want 01", {sb_ready[0], sw_ready[0]});
        end
        total++;
        sb_valid[0] = 1'b0;
        sw_valid[0] = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        logic [127:0] exp;
        logic [127:0] wexp;
        int n;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp = model_sub(d, 16);
        wexp = model_sub({96'd0, 32'hc0ffee11}, 4);
        sb_valid[0] = 1'b1;
        sb_data[0] = d;
        #1;
        step();
        sb_valid[0] = 1'b0;
        sw_valid[0] = 1'b1;
        sw_word[0] = 32'hc0ffee11;
        n = 0;
        while (!sb_out_valid[0] && n < 20) begin step(); n++; end
        for (int c = 0; c < 10; c++) begin
            if (sb_out[0] !== exp || sb_out_valid[0] !== 1'b1 || sw_ready[0] !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc%0d: got out=%h v=%b sw_ready=%b want %h 1 0", c,
                         sb_out[0], sb_out_valid[0], sw_ready[0], exp);
            end
            total++;
            step();
        end
        sb_out_ready[0] = 1'b1;
        step();
        sb_out_ready[0] = 1'b0;
        if (sb_out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || sw_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got v=%b busy=%b sw_ready=%b want 0 0 1", sb_out_valid[0],
                     busy[0], sw_ready[0]);
        end
        total++;
        step();
        sw_valid[0] = 1'b0;
        step();
        if (sw_out_valid[0] !== 1'b1 || sw_out[0] !== wexp[31:0]) begin
            bad++;
            $display("FAIL bp_sw_follow: got v=%b out=%h want 1 %h", sw_out_valid[0], sw_out[0], wexp[31:0]);
        end
        total++;
        sw_out_ready[0] = 1'b1;
        step();
        sw_out_ready[0] = 1'b0;
    endtask

    task automatic test_midreset();
        bit seen;
        sb_valid[0] = 1'b1;
        sb_data[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
        #1;
        step();
        sb_valid[0] = 1'b0;
        sb_out_ready[0] = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        if ({sb_out_valid[0], sw_out_valid[0], busy[0]} !== 3'b000 || sb_out[0] !== 128'd0 ||
            sw_out[0] !== 32'd0 || {sb_ready[0], sw_ready[0]} !== 2'b11) begin
            bad++;
            $display("FAIL midreset_state: got sbv=%b swv=%b busy=%b sb=%h sw=%h rdy=%b want zeros, rdy=11",
                     sb_out_valid[0], sw_out_valid[0], busy[0], sb_out[0], sw_out[0],
                     {sb_ready[0], sw_ready[0]});
        end
        total++;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (sb_out_valid[0] || busy[0]) seen = 1'b1;
            step();
        end
        sb_out_ready[0] = 1'b0;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL midreset_quiet: got activity=%b want 0", seen);
        end
        total++;
        run_sb_job(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        sb_valid = '0;
        sb_out_ready = '0;
        sw_valid = '0;
        sw_out_ready = '0;
        for (int k = 0; k < 3; k++) begin
            sb_data[k] = '0;
            sw_word[k] = '0;
        end
        build_table();
        test_reset();
        test_tie();
        for (int k = 0; k < 3; k++) test_vectors(k);
        test_backpressure();
        test_midreset();
        for (int k = 0; k < 3; k++) test_random(k);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sbox_share_ctrl.md
Name: sbox_share_ctrl

Overview:
- Time-multiplexes a bank of LANES combinational S-box instances between two requesters.
- Requester SB is the SubBytes datapath: 128-bit state, 16 bytes.
- Requester SW is the key-expansion SubWord path: 32-bit word, 4 bytes.
- Each requester has its own valid/ready input and output handshake. Arbitration is round-robin on ties; no preemption once a job is accepted.

Parameters:
- LANES, 4, number of sbox instances (bytes substituted per cycle); legal values are 1, 2 and 4 only; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- sb_valid  in  1  SubBytes request valid
- sb_ready  out  1  SubBytes request accepted this cycle when high with sb_valid
- sb_data  in  128  state to substitute; byte i = bits [8i+7:8i]
- sb_out_valid  out  1  SubBytes result valid
- sb_out_ready  in  1  SubBytes result consumer ready
- sb_out  out  128  substituted state, same byte order
- sw_valid  in  1  SubWord request valid
- sw_ready  out  1  SubWord request accepted
- sw_word  in  32  word to substitute; byte i = bits [8i+7:8i]
- sw_out_valid  out  1  SubWord result valid
- sw_out_ready  in  1  SubWord result consumer ready
- sw_out  out  32  substituted word
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (synchronous, active-high rst): state=IDLE, pass counter=0, last_grant=SB; all result registers and outputs 0; every valid and ready output low except the IDLE-derived readys below.
- States:
  - IDLE
  - RUN_SB
  - RUN_SW
  - DONE_SB
  - DONE_SW
- Ready generation is registered-state based only, with no combinational path from any out_ready:
  - sb_ready = IDLE && (!sw_valid || last_grant==SW)
  - sw_ready = IDLE && (!sb_valid || last_grant==SB)
- Tie rule: when both are valid in IDLE, the requester not granted last wins. After reset, the first tie goes to SW.
- Accept (valid && ready at an edge):
  - capture the input into the work register
  - clear the result register
  - set pass counter to 0 and last_grant to the winner
  - go to RUN_SB or RUN_SW
- RUN pass:
  - Each cycle, bytes [cnt*LANES .. cnt*LANES+LANES-1] of the work register go through the sbox lanes.
  - Results are written into the same byte positions of the result register, then cnt increments.
  - Pass count P = 16/LANES for SB and 4/LANES for SW.
  - After pass P-1, go to DONE_x.
- Latency: request accepted at edge T → RUN at edges T+1..T+P → out_valid high from the cycle after edge T+P.
  - LANES=4 gives SB 4 cycles and SW 1 cycle.
- DONE_x:
  - x_out_valid = 1 and x_out is held stable until the x_out_ready handshake, then go to IDLE.
  - The other requester's ready stays low throughout.
  - Minimum one IDLE cycle between jobs.
- x_out retains the last result after valid drops. Consumers must sample it only while valid.
- Input changes after accept are ignored; the work register is authoritative.
- Simultaneous events:
  - a request arriving during RUN/DONE waits (ready low, valid held by the requester)
  - out_ready asserted before out_valid has no effect
- rst mid-job: the job is discarded, no output valid is produced, and the state returns to IDLE with reset values on the next edge.
- Only one of sb_out_valid and sw_out_valid is ever high.

Decomposition:
- Shared package aes_sbox_pkg holds:
  - state enum
  - BYTE_W=8
  - SB_BYTES=16 and SW_BYTES=4
  - pass-count constants/function of LANES
  - LANES legality check
- Sub-module: the existing sbox (8-bit combinational lookup), instantiated LANES times in a generate loop.
- Lane mux/demux and the FSM stay in this module.

Test Plan:
1. SB only, LANES=4: sb_data bytes 0x00..0x0f (byte0=0x00). sb_out bytes are 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76. Valid rises 4 cycles after the accept edge.
2. SW only: sw_word=0xff7d0052 → sw_out=0x16ff6300, with sw_out_valid 1 cycle after accept. Also sw_word=0x00000000 → 0x63636363.
3. Tie out of reset: sb_valid and sw_valid high together.
   - SW is granted first; SB is granted after SW's DONE handshake.
   - On the next tie, SW is granted, because SB was the last grant.
4. Backpressure: hold sb_out_ready=0 for 10 cycles in DONE_SB.
   - sb_out stays stable and sw_ready stays low.
   - The release yields IDLE, and then the SW accept follows.
5. Reset mid-job: assert rst at RUN_SB pass 2.
   - Next cycle: IDLE, all outputs 0, no out_valid.
   - A following request completes correctly.
6. LANES=1 and LANES=2 regressions of tests 1 and 2: SB latency 16 and 8 cycles, SW latency 4 and 2 cycles, with identical results.
